// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants for stage registers.
package pipe_stage_reg_pkg;
    localparam int REG_IDX_W  = 5;
    localparam int PC_W       = 32;
    localparam int DEF_CTRL_W = 3;
    localparam int DEF_DATA_W = 64;

    // Number of held entries from the two valid bits.
    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/pipe_entry.sv
// One storage slot: a valid bit plus a payload register with load enable.
// Both clear asynchronously; the payload resets to RESET_VAL.
module pipe_entry #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         vld_d,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    // Valid bit follows vld_d every cycle; payload only changes on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= 1'b0;
            q   <= RESET_VAL;
        end else begin
            vld <= vld_d;
            if (load)
                q <= d;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a skid slot: registered in_ready, one-cycle
// latency, flush, and bubble gating of the control bits.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          CTRL_W   = DEF_CTRL_W,
    parameter logic [31:0] PC_RESET = 32'h00000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [DATA_W-1:0]    out_data,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [1:0]           occupancy
);
    localparam int PAY_W = PC_W + DATA_W + CTRL_W + REG_IDX_W;
    localparam logic [PAY_W-1:0] MAIN_RST = {PC_RESET, {(DATA_W + CTRL_W + REG_IDX_W){1'b0}}};

    logic             main_vld, skid_vld;
    logic             main_load, skid_load, main_vld_d, skid_vld_d;
    logic [PAY_W-1:0] main_d, main_q, skid_q, in_pay;
    logic             accept, drain;
    logic [CTRL_W-1:0] held_ctrl;

    assign in_pay   = {in_pc, in_data, in_ctrl, in_rd};
    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign drain    = main_vld && out_ready;

    // Slot control: flush clears both valids (payload kept), otherwise
    // skid refills main on drain, and new words go to main or skid.
    always_comb begin
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_pay;
        main_vld_d = main_vld;
        skid_vld_d = skid_vld;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld) begin
            if (drain) begin
                main_load  = 1'b1;
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld || drain) begin
                main_load  = 1'b1;
                main_vld_d = 1'b1;
            end else begin
                skid_load  = 1'b1;
                skid_vld_d = 1'b1;
            end
        end else if (drain) begin
            main_vld_d = 1'b0;
        end
    end

    pipe_entry #(.W(PAY_W), .RESET_VAL(MAIN_RST)) u_main (
        .clk(clk), .reset(reset), .load(main_load), .vld_d(main_vld_d),
        .d(main_d), .vld(main_vld), .q(main_q)
    );

    pipe_entry #(.W(PAY_W), .RESET_VAL('0)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .vld_d(skid_vld_d),
        .d(in_pay), .vld(skid_vld), .q(skid_q)
    );

    assign {out_pc, out_data, held_ctrl, out_rd} = main_q;
    assign out_valid = main_vld;
    // Bubbles must never assert control bits downstream.
    assign out_ctrl  = main_vld ? held_ctrl : '0;
    assign occupancy = count_valid(main_vld, skid_vld);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a queue model of the two-deep stage.
module tb_pipe_stage_reg;
    localparam logic [31:0] PC_RST = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] data;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    word_t       iw = '0;
    logic [31:0] out_pc;
    logic [63:0] out_data;
    logic [2:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    // Model: queue of held words in acceptance order, plus last shown word.
    word_t mq[$];
    word_t shown;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(iw.pc), .in_data(iw.data), .in_ctrl(iw.ctrl), .in_rd(iw.rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic word_t rand_word();
        word_t w;
        w.pc   = $urandom & 32'hFFFF_FFFC;
        w.data = {$urandom, $urandom};
        w.ctrl = 3'($urandom);
        w.rd   = 5'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        shown = '{pc: PC_RST, data: '0, ctrl: '0, rd: '0};
    endtask

    // Advance one clock, updating the model from the stage's transfer rules.
    task automatic tick();
        bit rdy, ov;
        rdy = (mq.size() < 2);
        ov  = (mq.size() > 0);
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (ov && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back(iw);
        end
        if (mq.size() > 0) shown = mq[0];
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
        checks++; if (out_pc !== PC_RST) begin errors++; $display("FAIL rst_pc: got %h exp %h", out_pc, PC_RST); end
        checks++; if (out_data !== 64'd0 || out_rd !== 5'd0 || out_ctrl !== 3'd0) begin
            errors++; $display("FAIL rst_fields: got data=%h rd=%h ctrl=%h exp zeros", out_data, out_rd, out_ctrl); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            iw = rand_word();
            iw.pc = 32'(i * 4);
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
                errors++; $display("FAIL b2b_word%0d: got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4)); end
            checks++; if (occupancy > 2'd1 || out_data !== iw.data) begin
                errors++; $display("FAIL b2b_occ_data%0d: got occ=%0d data=%h exp occ<=1 data=%h", i, occupancy, out_data, iw.data); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL b2b_empty: got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            iw = rand_word();
            iw.pc = 32'h100 + 32'(i * 4);
            tick();
            checks++; if (out_pc !== 32'h100 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b pc=%h exp v=1 pc=00000100", i, out_valid, out_pc); end
            checks++; if (occupancy !== 2'(i == 0 ? 1 : 2) || in_ready !== (i == 0)) begin
                errors++; $display("FAIL bp_occ%0d: got occ=%0d rdy=%b exp occ=%0d rdy=%b", i, occupancy, in_ready, (i == 0 ? 1 : 2), (i == 0)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_release();
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h104 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
            errors++; $display("FAIL rel_second: got v=%b pc=%h occ=%0d exp 1/00000104/1", out_valid, out_pc, occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'h104) begin
            errors++; $display("FAIL rel_empty: got v=%b occ=%0d pc=%h exp 0/0/00000104", out_valid, occupancy, out_pc); end
    endtask

    task automatic test_flush();
        logic [31:0] first_pc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        iw = rand_word(); iw.pc = 32'h200; iw.ctrl = 3'b111; first_pc = iw.pc; tick();
        iw = rand_word(); iw.pc = 32'h204; tick();
        iw = rand_word(); iw.pc = 32'h40;
        flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 3'd0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear: got v=%b ctrl=%h occ=%0d rdy=%b exp 0/0/0/1", out_valid, out_ctrl, occupancy, in_ready); end
        checks++; if (out_pc !== first_pc) begin errors++; $display("FAIL flush_keep_pc: got %h exp %h", out_pc, first_pc); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_pc === 32'h40) begin
                errors++; $display("FAIL flush_no40_%0d: got v=%b pc=%h exp v=0 pc!=00000040", i, out_valid, out_pc); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        iw = rand_word(); tick();
        iw = rand_word(); tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_full: got %0d exp 2", occupancy); end
        #2 reset = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_ctrl !== 3'd0) begin
            errors++; $display("FAIL ar_state: got v=%b occ=%0d rdy=%b ctrl=%h exp 0/0/1/0", out_valid, occupancy, in_ready, out_ctrl); end
        checks++; if (out_pc !== PC_RST || out_data !== 64'd0 || out_rd !== 5'd0) begin
            errors++; $display("FAIL ar_fields: got pc=%h data=%h rd=%h exp %h/0/0", out_pc, out_data, out_rd, PC_RST); end
        #1 reset = 1'b0;
        model_reset();
        in_valid = 1'b1; iw = rand_word();
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== iw.pc) begin
            errors++; $display("FAIL ar_first_accept: got v=%b pc=%h exp 1/%h", out_valid, out_pc, iw.pc); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_bubble();
        in_valid = 1'b0;
        iw.ctrl = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_ctrl !== 3'd0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL bubble%0d: got ctrl=%h v=%b exp 0/0", i, out_ctrl, out_valid); end
        end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 4);
            iw        = rand_word();
            tick();
            n = mq.size();
            checks++; if (out_valid !== (n > 0) || occupancy !== 2'(n) || in_ready !== (n < 2)) begin
                errors++; $display("FAIL rnd_ctl c%0d: got v=%b occ=%0d rdy=%b exp occ=%0d", c, out_valid, occupancy, in_ready, n); end
            checks++; if (out_pc !== shown.pc || out_data !== shown.data || out_rd !== shown.rd) begin
                errors++; $display("FAIL rnd_pay c%0d: got pc=%h data=%h rd=%h exp pc=%h data=%h rd=%h",
                                   c, out_pc, out_data, out_rd, shown.pc, shown.data, shown.rd); end
            checks++; if (out_ctrl !== (n > 0 ? shown.ctrl : 3'd0)) begin
                errors++; $display("FAIL rnd_ctrl c%0d: got %h exp %h", c, out_ctrl, (n > 0 ? shown.ctrl : 3'd0)); end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_release();
        test_flush();
        test_async_reset();
        test_bubble();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width; default carries ALU result plus write data.
REQ-002 Parameter CTRL_W, default 3: control-bit width (e.g. MemtoReg[1:0], RegWrite).
REQ-003 Parameter PC_RESET, default 32'h00000000: value of out_pc after reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready.
REQ-008 in_pc  input  32  instruction PC.
REQ-009 in_data  input  DATA_W  payload.
REQ-010 in_ctrl  input  CTRL_W  control bits.
REQ-011 in_rd  input  5  destination register index.
REQ-012 flush  input  1  discard all held instructions.
REQ-013 out_valid  output  1  output holds a valid instruction.
REQ-014 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-015 out_pc, out_data, out_ctrl, out_rd  output  32/DATA_W/CTRL_W/5  held instruction fields.
REQ-016 occupancy  output  2  number of held entries, 0..2.

Function
REQ-017 Storage is two entries: main (drives outputs) and skid; each has a valid bit.
REQ-018 in_ready is registered: in_ready = !skid_valid; it never depends combinationally on out_ready.
REQ-019 Latency is one cycle: a word accepted at edge N appears on the outputs after edge N when main is empty or drains at edge N.
REQ-020 Accept while main is empty, or main drains this cycle with skid empty: the word loads into main.
REQ-021 Accept while main is held (out_valid && !out_ready): the word loads into skid; in_ready falls next cycle.
REQ-022 Main drains while skid is valid: skid moves to main and skid_valid clears; no new word is accepted that cycle (in_ready was 0).
REQ-023 Simultaneous accept and drain with main valid and skid empty: the new word replaces main; occupancy stays 1.
REQ-024 out_ctrl is forced to all-zero whenever out_valid=0, so bubbles never assert RegWrite/MemtoReg downstream.
REQ-025 Held payload is stable while out_valid && !out_ready; no field changes until the transfer.
REQ-026 Flush: at the next edge main_valid=0, skid_valid=0, occupancy=0 and in_ready=1; out_pc/out_data/out_rd keep their last values.
REQ-027 Flush with simultaneous accept: flush wins and the incoming word is discarded.
REQ-028 Flush with simultaneous drain: the downstream transfer that cycle completes; only the stored state is cleared.
REQ-029 Ordering: words leave in acceptance order; no loss or duplication.

Reset
REQ-030 On reset (asynchronous assert): out_valid=0, skid_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_pc=PC_RESET, out_data=0, out_rd=0.
REQ-031 Reset asserted mid-operation discards held entries immediately, without waiting for a clock edge.
REQ-032 First accept is possible at the first rising edge after reset deasserts.

Structure
REQ-033 The shared pipeline package holds REG_IDX_W=5, PC_W=32 and the default CTRL_W/DATA_W constants.
REQ-034 A single sub-module, pipe_entry (one valid bit plus payload register with load enable and async clear), is instantiated twice, as main and as skid.

Verification
REQ-035 Back-to-back stream: 8 words with PC 0x0,0x4,...,0x1C and out_ready=1 -> each appears one cycle later in order; occupancy never exceeds 1.
REQ-036 Backpressure: out_ready=0 and 3 words offered -> 2 accepted; in_ready=0 after the second; occupancy=2; out_pc holds the first PC stable.
REQ-037 Release: from occupancy=2 set out_ready=1 -> words out in order on consecutive cycles; in_ready returns to 1 one cycle after the skid drains.
REQ-038 Flush while full, with in_valid=1 (PC 0x40) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; PC 0x40 never appears at the output.
REQ-039 Async reset pulse mid-cycle while occupancy=2 -> outputs reach the reset values of REQ-030 before the next edge; out_pc=PC_RESET.
REQ-040 Bubble gating: in_ctrl=3'b111 with in_valid=0 for 4 cycles -> out_ctrl stays 0 and out_valid stays 0.
